// File: rtl/dlx_pkg.sv
// Shared DLX pipeline types and widths.
package dlx_pkg;

   localparam int unsigned REG_W = 5;
   localparam int unsigned XLEN  = 32;

   // Encoding 2'b11 is not named and is treated as a word access.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } mem_size_t;

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_stage_if.sv
// Write-back stage bus: MEM-stage handshake, data-memory response and register-file write port.
interface wb_stage_if;
   import dlx_pkg::*;

   logic              mem_valid;
   logic              mem_ready;
   logic [REG_W-1:0]  mem_rd;
   logic [XLEN-1:0]   mem_result;
   logic              mem_is_load;
   logic [1:0]        mem_size;
   logic              mem_unsigned;
   logic              dmem_rvalid;
   logic [XLEN-1:0]   dmem_rdata;
   logic              WB;
   logic [REG_W-1:0]  Rd;
   logic [XLEN-1:0]   reg_s;
   logic              load_pending;
   logic [REG_W-1:0]  load_rd;
   logic              err_timeout;
   logic              err_misaligned;
   logic [XLEN-1:0]   retired;

   modport master (
      output mem_valid, mem_rd, mem_result, mem_is_load, mem_size, mem_unsigned,
             dmem_rvalid, dmem_rdata,
      input  mem_ready, WB, Rd, reg_s, load_pending, load_rd, err_timeout,
             err_misaligned, retired
   );

   modport slave (
      input  mem_valid, mem_rd, mem_result, mem_is_load, mem_size, mem_unsigned,
             dmem_rvalid, dmem_rdata,
      output mem_ready, WB, Rd, reg_s, load_pending, load_rd, err_timeout,
             err_misaligned, retired
   );

endinterface

// File: rtl/load_align.sv
// Load data formatter: picks the addressed byte/half out of a 32-bit word and extends it.
module load_align
   import dlx_pkg::*;
(
   input  logic [XLEN-1:0] i_rdata,
   input  logic [1:0]      i_off,
   input  logic [1:0]      i_size,
   input  logic            i_unsigned,
   output logic [XLEN-1:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      // Only off[1] matters for halves; off[0] is flagged elsewhere as misaligned.
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
   end

   always_comb begin
      o_result = i_rdata;
      case (i_size)
         SZ_BYTE: o_result = {{24{~i_unsigned & w_byte[7]}}, w_byte};
         SZ_HALF: o_result = {{16{~i_unsigned & w_half[15]}}, w_half};
         default: o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// DLX write-back stage: retires ALU results immediately and loads after the memory response.
module wb_stage
   import dlx_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   wb_stage_if.slave  bus
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   wb_state_t         r_state;
   logic [REG_W-1:0]  r_ld_rd;
   logic [1:0]        r_ld_size;
   logic [1:0]        r_ld_off;
   logic              r_ld_uns;
   logic [7:0]        r_cnt;
   logic              r_wb;
   logic [REG_W-1:0]  r_rd;
   logic [XLEN-1:0]   r_reg_s;
   logic              r_err_to;
   logic              r_err_mis;
   logic [XLEN-1:0]   r_retired;
   logic [XLEN-1:0]   w_ld_data;

   load_align u_load_align (
      .i_rdata    (bus.dmem_rdata),
      .i_off      (r_ld_off),
      .i_size     (r_ld_size),
      .i_unsigned (r_ld_uns),
      .o_result   (w_ld_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_ld_rd   <= '0;
         r_ld_size <= '0;
         r_ld_off  <= '0;
         r_ld_uns  <= 1'b0;
         r_cnt     <= '0;
         r_wb      <= 1'b0;
         r_rd      <= '0;
         r_reg_s   <= '0;
         r_err_to  <= 1'b0;
         r_err_mis <= 1'b0;
         r_retired <= '0;
      end else begin
         r_wb <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.mem_valid) begin
                  if (bus.mem_is_load) begin
                     r_ld_rd   <= bus.mem_rd;
                     r_ld_size <= bus.mem_size;
                     r_ld_off  <= bus.mem_result[1:0];
                     r_ld_uns  <= bus.mem_unsigned;
                     r_cnt     <= '0;
                     r_state   <= WAIT_LOAD;
                     if (bus.mem_size == SZ_HALF && bus.mem_result[0]) begin
                        r_err_mis <= 1'b1;
                     end
                  end else begin
                     r_wb      <= |bus.mem_rd;
                     r_rd      <= bus.mem_rd;
                     r_reg_s   <= bus.mem_result;
                     r_retired <= r_retired + XLEN'(|bus.mem_rd);
                  end
               end
            end
            WAIT_LOAD: begin
               // A response on the limit cycle takes priority over the abort.
               if (bus.dmem_rvalid) begin
                  r_wb      <= |r_ld_rd;
                  r_rd      <= r_ld_rd;
                  r_reg_s   <= w_ld_data;
                  r_retired <= r_retired + XLEN'(|r_ld_rd);
                  r_ld_rd   <= '0;
                  r_state   <= IDLE;
               end else if (r_cnt == LIMIT) begin
                  r_err_to <= 1'b1;
                  r_ld_rd  <= '0;
                  r_state  <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.mem_ready      = (r_state == IDLE);
   assign bus.load_pending   = (r_state == WAIT_LOAD);
   assign bus.load_rd        = r_ld_rd;
   assign bus.WB             = r_wb;
   assign bus.Rd             = r_rd;
   assign bus.reg_s          = r_reg_s;
   assign bus.err_timeout    = r_err_to;
   assign bus.err_misaligned = r_err_mis;
   assign bus.retired        = r_retired;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases then random ALU/load traffic against a behavioural model.
module tb_wb_stage;

   localparam int unsigned TO = 4;

   logic clk;
   logic reset;

   wb_stage_if bus_if ();

   wb_stage #(
      .TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec  = 0;
   int unsigned n_fail = 0;

   // Model state
   logic [31:0] m_retired;
   logic        m_err_to;
   logic        m_err_mis;
   logic [4:0]  m_rd;
   logic [31:0] m_reg_s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] addr,
                                            input logic [1:0] sz, input logic u);
      int unsigned off;
      logic [31:0] v;
      off = {30'b0, addr[1:0]};
      if (sz == 2'd0) begin
         v = (w >> (8 * off)) & 32'h0000_00FF;
         if (!u && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (16 * (off / 2))) & 32'h0000_FFFF;
         if (!u && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   task automatic chk_wb(input string tag, input logic wr);
      chk({tag, ".WB"}, 32'(bus_if.WB), 32'(wr));
      chk({tag, ".Rd"}, 32'(bus_if.Rd), 32'(m_rd));
      chk({tag, ".reg_s"}, bus_if.reg_s, m_reg_s);
      chk({tag, ".retired"}, bus_if.retired, m_retired);
   endtask

   task automatic chk_flags(input string tag);
      chk({tag, ".err_to"}, 32'(bus_if.err_timeout), 32'(m_err_to));
      chk({tag, ".err_mis"}, 32'(bus_if.err_misaligned), 32'(m_err_mis));
   endtask

   task automatic do_alu(input logic [4:0] rd, input logic [31:0] res);
      chk("alu.ready", 32'(bus_if.mem_ready), 32'd1);
      bus_if.mem_valid   = 1'b1;
      bus_if.mem_is_load = 1'b0;
      bus_if.mem_rd      = rd;
      bus_if.mem_result  = res;
      step();
      bus_if.mem_valid = 1'b0;
      m_rd    = rd;
      m_reg_s = res;
      if (rd != 5'd0) m_retired = m_retired + 32'd1;
      chk_wb("alu", rd != 5'd0);
      chk("alu.pending", 32'(bus_if.load_pending), 32'd0);
   endtask

   task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] sz,
                          input logic u, input logic [31:0] w, input int unsigned waits);
      bus_if.mem_valid    = 1'b1;
      bus_if.mem_is_load  = 1'b1;
      bus_if.mem_rd       = rd;
      bus_if.mem_result   = addr;
      bus_if.mem_size     = sz;
      bus_if.mem_unsigned = u;
      step();
      bus_if.mem_valid  = 1'b0;
      bus_if.dmem_rdata = $urandom();
      if (sz == 2'd1 && addr[0]) m_err_mis = 1'b1;
      chk("ld.acc.pending", 32'(bus_if.load_pending), 32'd1);
      chk("ld.acc.load_rd", 32'(bus_if.load_rd), 32'(rd));
      chk("ld.acc.ready", 32'(bus_if.mem_ready), 32'd0);
      chk("ld.acc.WB", 32'(bus_if.WB), 32'd0);
      chk_flags("ld.acc");
      for (int k = 1; k <= int'(waits); k++) begin
         step();
         if (k < int'(TO)) begin
            chk("ld.wait.pending", 32'(bus_if.load_pending), 32'd1);
            chk("ld.wait.ready", 32'(bus_if.mem_ready), 32'd0);
            chk("ld.wait.WB", 32'(bus_if.WB), 32'd0);
         end else begin
            m_err_to = 1'b1;
            chk("ld.to.pending", 32'(bus_if.load_pending), 32'd0);
            chk("ld.to.load_rd", 32'(bus_if.load_rd), 32'd0);
            chk("ld.to.ready", 32'(bus_if.mem_ready), 32'd1);
            chk("ld.to.WB", 32'(bus_if.WB), 32'd0);
            chk_flags("ld.to");
            break;
         end
      end
      if (waits < TO) begin
         bus_if.dmem_rvalid = 1'b1;
         bus_if.dmem_rdata  = w;
         step();
         bus_if.dmem_rvalid = 1'b0;
         bus_if.dmem_rdata  = $urandom();
         m_rd    = rd;
         m_reg_s = ref_load(w, addr, sz, u);
         if (rd != 5'd0) m_retired = m_retired + 32'd1;
         chk_wb("ld", rd != 5'd0);
         chk("ld.done.pending", 32'(bus_if.load_pending), 32'd0);
         chk("ld.done.load_rd", 32'(bus_if.load_rd), 32'd0);
         chk("ld.done.ready", 32'(bus_if.mem_ready), 32'd1);
         chk_flags("ld.done");
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk_wb(tag, 1'b0);
      chk_flags(tag);
      chk({tag, ".pending"}, 32'(bus_if.load_pending), 32'd0);
      chk({tag, ".load_rd"}, 32'(bus_if.load_rd), 32'd0);
      chk({tag, ".ready"}, 32'(bus_if.mem_ready), 32'd1);
   endtask

   task automatic model_reset();
      m_retired = '0;
      m_err_to  = 1'b0;
      m_err_mis = 1'b0;
      m_rd      = '0;
      m_reg_s   = '0;
   endtask

   initial begin
      reset               = 1'b1;
      bus_if.mem_valid    = 1'b0;
      bus_if.mem_rd       = '0;
      bus_if.mem_result   = '0;
      bus_if.mem_is_load  = 1'b0;
      bus_if.mem_size     = '0;
      bus_if.mem_unsigned = 1'b0;
      bus_if.dmem_rvalid  = 1'b0;
      bus_if.dmem_rdata   = '0;
      model_reset();
      step();
      step();
      reset = 1'b0;
      chk_reset_state("rst");

      do_alu(5'd7, 32'hDEAD_BEEF);
      do_load(5'd3, 32'h0000_1002, 2'd0, 1'b0, 32'h00A5_0000, 0);
      do_load(5'd3, 32'h0000_1002, 2'd0, 1'b1, 32'h00A5_0000, 0);
      do_load(5'd9, 32'h0000_2003, 2'd1, 1'b0, 32'h8001_0000, 2);
      do_load(5'd4, 32'h0000_3000, 2'd2, 1'b0, 32'h1234_5678, TO - 1);
      do_load(5'd5, 32'h0000_3000, 2'd2, 1'b0, 32'h1234_5678, TO);
      do_alu(5'd0, 32'h1234_5678);

      // A stray response while idle must not write back.
      bus_if.dmem_rvalid = 1'b1;
      bus_if.dmem_rdata  = 32'hCAFE_F00D;
      step();
      bus_if.dmem_rvalid = 1'b0;
      chk_wb("idle_rvalid", 1'b0);
      chk_flags("idle_rvalid");

      // Reset mid-load, then a late response.
      bus_if.mem_valid   = 1'b1;
      bus_if.mem_is_load = 1'b1;
      bus_if.mem_rd      = 5'd12;
      bus_if.mem_result  = 32'h0;
      bus_if.mem_size    = 2'd2;
      step();
      bus_if.mem_valid = 1'b0;
      chk("rstld.pending", 32'(bus_if.load_pending), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      bus_if.dmem_rvalid = 1'b1;
      bus_if.dmem_rdata  = 32'h5555_AAAA;
      step();
      bus_if.dmem_rvalid = 1'b0;
      chk_reset_state("rstld");
      step();
      chk_reset_state("rstld2");

      for (int t = 0; t < 80; t++) begin
         logic [4:0] rd;
         rd = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 5) == 0) rd = 5'd0;
         if ($urandom_range(0, 1) == 1) begin
            do_alu(rd, $urandom());
         end else begin
            do_load(rd, $urandom(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    $urandom(), $urandom_range(0, 5));
         end
         if ($urandom_range(0, 3) == 0) begin
            bus_if.dmem_rvalid = 1'b1;
            bus_if.dmem_rdata  = $urandom();
            step();
            bus_if.dmem_rvalid = 1'b0;
            chk_wb("rnd_idle", 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
